uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that sits directly downstream of the UART transmit path and consumes the frames it puts on the line.
- Oversamples the asynchronous rx line, detects and validates the start bit, and samples each data bit at mid-bit.
- Optionally checks an even-parity bit, checks the stop bit, and presents each byte as a single-cycle valid pulse with error flags.
- Frame format: 1 start (0), DATA_BITS data LSB-first, optional even parity, 1 stop (1).

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=4)
DATA_BITS, 8, data bits per frame (1..8)

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
sample_tick  input  1  single-cycle strobe at OVERSAMPLE x baud rate
rx_in  input  1  asynchronous serial line, idle high
parity_en  input  1  1 = frame carries an even-parity bit after data
rx_data  output  DATA_BITS  last received byte, held until the next rx_valid
rx_valid  output  1  one-clk pulse: rx_data and error flags updated
parity_err  output  1  parity mismatch on the last frame (0 when parity disabled)
frame_err  output  1  stop bit sampled as 0 on the last frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk.
- Reset values:
  - outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - internals: state=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value rxs and its previous value rxs_d.
- Everything except rx_valid advances only on cycles where sample_tick=1.
- Counters:
  - tick_cnt: $clog2(OVERSAMPLE) bits.
  - bit_cnt: $clog2(DATA_BITS)+1 bits.
- States:
  - IDLE: on tick with rxs_d=1 and rxs=0 (falling edge), set tick_cnt=0 -> START. A line held low does not retrigger.
  - START: tick_cnt increments per tick. At tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxs=0: latch parity_en, clear tick_cnt and bit_cnt -> DATA.
    - rxs=1: false start -> IDLE, no rx_valid.
  - DATA: at tick_cnt==OVERSAMPLE-1, shift rxs into the MSB of the shift register (shift right, LSB-first), bit_cnt++, tick_cnt=0. tick_cnt wraps to 0 every OVERSAMPLE ticks. When bit_cnt reaches DATA_BITS -> PARITY if latched parity_en, else STOP.
  - PARITY: at tick_cnt==OVERSAMPLE-1, store perr = rxs ^ (XOR of data bits) -> STOP.
  - STOP: at tick_cnt==OVERSAMPLE-1, sample rxs -> IDLE, and in the same clk register rx_data, parity_err=perr (0 if parity disabled) and frame_err=~rxs.
- rx_valid=1 for exactly the clk cycle after that stop-sample tick.
- A frame with an error still produces rx_valid, with the flag set.
- Error flags are sticky only until the next rx_valid, which overwrites them.
- parity_en changes during a frame have no effect on that frame; the value latched at start acceptance is used.
- A falling edge on rxs outside IDLE is ignored.
- busy=0 only in IDLE.
- sample_tick absent: no state advance, and the FSM never times out.
- Reset mid-frame: immediate return to IDLE, partial byte discarded, no rx_valid.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP), encoded in 3 bits.
  - frame constants START_BIT=0, STOP_BIT=1.
  - default OVERSAMPLE and DATA_BITS.
- One sub-module, uart_rx_sync: 2-flop synchroniser with reset value 1, plus a falling-edge detect output (rxs_d & ~rxs).

Test Plan:
- Reset, line idle high, OVERSAMPLE=16, sample_tick every 4 clk, parity_en=0; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- parity_en=1:
  - send 0x03 with parity bit 0 -> rx_data=0x03, parity_err=0.
  - send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
- Glitch: line low for 4 ticks (< OVERSAMPLE/2) then high -> no rx_valid, busy returns to 0, next good frame 0x3C received correctly.
- Stop bit forced 0 on frame 0xFF, then line held low 40 ticks -> one rx_valid with frame_err=1, rx_data=0xFF, no further frames until the line returns high and a new falling edge occurs.
- nrst asserted mid-DATA of frame 0x55 -> outputs return to 0 immediately, no rx_valid; after release, frame 0x81 received correctly.
- Back-to-back frames 0x12 and 0x34 with no idle gap, plus baud ±3% tick-rate skew -> two rx_valid pulses with correct data and no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame: start(0), LSB-first data, optional even parity, stop(1).
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus: byte, valid strobe, error flags and busy.
// The receiver drives it through master; consumers read it through slave.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx line (idle high) plus a falling-edge
// detect measured between consecutive sample ticks.
module uart_rx_sync (
    input  logic clk,
    input  logic nrst,
    input  logic i_tick,
    input  logic i_rx,
    output logic o_rxs,
    output logic o_fall
);
    logic r_meta;
    logic r_rxs;
    logic r_rxs_d;

    // rxs_d only moves on ticks so an edge between ticks is still seen on the next tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta  <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_rxs  <= r_meta;
            if (i_tick)
                r_rxs_d <= r_rxs;
        end
    end

    assign o_rxs  = r_rxs;
    assign o_fall = r_rxs_d & ~r_rxs;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: validates the start bit at mid-bit, samples
// data/parity/stop at bit centres and reports each frame with a 1-clk valid.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      sample_tick,
    input  logic      rx_in,
    input  logic      parity_en,
    uart_rx_if.master rx_bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic w_rxs;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .nrst   (nrst),
        .i_tick (sample_tick),
        .i_rx   (rx_in),
        .o_rxs  (w_rxs),
        .o_fall (w_fall)
    );

    rx_state_t            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_o;
    logic                 r_ferr;
    logic                 r_busy;

    logic [DATA_BITS-1:0] w_shift_nxt;

    generate
        if (DATA_BITS == 1) begin : g_one
            assign w_shift_nxt = w_rxs;
        end else begin : g_multi
            assign w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= RX_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_perr     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_o   <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_tick) begin
                case (r_state)
                    RX_IDLE: begin
                        if (w_fall) begin
                            r_tick_cnt <= '0;
                            r_state    <= RX_START;
                            r_busy     <= 1'b1;
                        end
                    end
                    RX_START: begin
                        if (r_tick_cnt == HALF_M1) begin
                            r_tick_cnt <= '0;
                            if (w_rxs == START_BIT) begin
                                // parity mode is frozen for the whole frame here
                                r_par_en  <= parity_en;
                                r_perr    <= 1'b0;
                                r_bit_cnt <= '0;
                                r_state   <= RX_DATA;
                            end else begin
                                r_state <= RX_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + T_ONE;
                        end
                    end
                    RX_DATA: begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_shift    <= w_shift_nxt;
                            r_bit_cnt  <= r_bit_cnt + B_ONE;
                            if (r_bit_cnt == LAST_BIT)
                                r_state <= r_par_en ? RX_PARITY : RX_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + T_ONE;
                        end
                    end
                    RX_PARITY: begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_perr     <= w_rxs ^ (^r_shift);
                            r_state    <= RX_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + T_ONE;
                        end
                    end
                    RX_STOP: begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_data     <= r_shift;
                            r_perr_o   <= r_par_en & r_perr;
                            r_ferr     <= (w_rxs != STOP_BIT);
                            r_valid    <= 1'b1;
                            r_state    <= RX_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + T_ONE;
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_bus.rx_data    = r_data;
    assign rx_bus.rx_valid   = r_valid;
    assign rx_bus.parity_err = r_perr_o;
    assign rx_bus.frame_err  = r_ferr;
    assign rx_bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversample, tick every 4 clk (64 clk/bit),
// frames driven bit by bit and results checked against hand-computed values.
module tb_uart_rx;

    logic clk;
    logic nrst;
    logic sample_tick;
    logic rx_in;
    logic parity_en;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    logic [7:0] cap[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .parity_en   (parity_en),
        .rx_bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            vcnt++;
            cap.push_back(bus.rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_on, input bit par_bit,
                              input bit stop_bit, input int bclk);
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(d[i], bclk);
        if (par_on) drive(par_bit, bclk);
        drive(stop_bit, bclk);
    endtask

    int n0;

    initial begin
        nrst      = 1'b0;
        rx_in     = 1'b1;
        parity_en = 1'b0;
        #22;
        check("rst_data",  bus.rx_data,    8'h00);
        check("rst_valid", bus.rx_valid,   1'b0);
        check("rst_perr",  bus.parity_err, 1'b0);
        check("rst_ferr",  bus.frame_err,  1'b0);
        check("rst_busy",  bus.busy,       1'b0);
        @(posedge clk); #1 nrst = 1'b1;
        drive(1'b1, 40);

        // plain 8N1 frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("a5_count", vcnt, 1);
        check("a5_data",  bus.rx_data,    8'hA5);
        check("a5_perr",  bus.parity_err, 1'b0);
        check("a5_ferr",  bus.frame_err,  1'b0);
        check("a5_busy",  bus.busy,       1'b0);

        // even parity: 0x03 correct, 0x07 wrong
        parity_en = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("p03_count", vcnt, 2);
        check("p03_data",  bus.rx_data,    8'h03);
        check("p03_perr",  bus.parity_err, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("p07_count", vcnt, 3);
        check("p07_data",  bus.rx_data,    8'h07);
        check("p07_perr",  bus.parity_err, 1'b1);
        check("p07_ferr",  bus.frame_err,  1'b0);
        parity_en = 1'b0;

        // short low glitch is rejected as a false start
        drive(1'b0, 12);
        check("glitch_busy_hi", bus.busy, 1'b1);
        drive(1'b0, 4);
        drive(1'b1, 100);
        check("glitch_count",   vcnt, 3);
        check("glitch_busy_lo", bus.busy, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("3c_count", vcnt, 4);
        check("3c_data",  bus.rx_data,    8'h3C);
        check("3c_perr",  bus.parity_err, 1'b0);

        // stop bit low then line stuck low: one frame, frame_err, no retrigger
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 64);
        drive(1'b0, 160);
        check("ferr_count", vcnt, 5);
        check("ferr_data",  bus.rx_data,   8'hFF);
        check("ferr_flag",  bus.frame_err, 1'b1);
        check("ferr_busy",  bus.busy,      1'b0);
        drive(1'b1, 64);
        check("ferr_norearm", vcnt, 5);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("5a_count", vcnt, 6);
        check("5a_data",  bus.rx_data,   8'h5A);
        check("5a_ferr",  bus.frame_err, 1'b0);

        // reset in the middle of DATA of 0x55
        drive(1'b0, 64);
        drive(1'b1, 64);
        drive(1'b0, 30);
        check("mid_busy_pre", bus.busy, 1'b1);
        nrst = 1'b0;
        #1;
        check("mid_rst_data",  bus.rx_data,    8'h00);
        check("mid_rst_valid", bus.rx_valid,   1'b0);
        check("mid_rst_perr",  bus.parity_err, 1'b0);
        check("mid_rst_ferr",  bus.frame_err,  1'b0);
        check("mid_rst_busy",  bus.busy,       1'b0);
        rx_in = 1'b1;
        repeat (20) @(posedge clk);
        #1 nrst = 1'b1;
        drive(1'b1, 100);
        check("mid_rst_count", vcnt, 6);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 64);
        drive(1'b1, 64);
        check("81_count", vcnt, 7);
        check("81_data",  bus.rx_data, 8'h81);

        // back-to-back frames, line 3% slow then 3% fast
        n0 = cap.size();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 66);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 62);
        drive(1'b1, 64);
        check("b2b_count", cap.size(), n0 + 2);
        if (cap.size() >= n0 + 2) begin
            check("b2b_first",  cap[n0],     8'h12);
            check("b2b_second", cap[n0 + 1], 8'h34);
        end
        check("b2b_perr", bus.parity_err, 1'b0);
        check("b2b_ferr", bus.frame_err,  1'b0);
        check("b2b_busy", bus.busy,       1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
